// File: rtl/lfsr_period_tester_if.sv
// lfsr_period_tester_if: dispatch-side bundle between the UART dispatcher and one polynomial tester
interface lfsr_period_tester_if #(
    parameter int BYTES = 4
);
    logic               ena;
    logic [BYTES*8-1:0] coeffs;
    logic               ready;
    logic               found;
    logic               failure;

    modport master (output ena, output coeffs, input ready, input found, input failure);
    modport slave  (input ena, input coeffs, output ready, output found, output failure);
endinterface

// File: rtl/lfsr_period_tester.sv
// lfsr_period_tester: measures the Galois LFSR period of a latched polynomial and flags primitive ones
module lfsr_period_tester #(
    parameter int SIZE  = 24,
    parameter int BYTES = 4
) (
    input logic                  clk,
    input logic                  res,
    lfsr_period_tester_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE_FOUND, DONE_FAIL} state_t;

    state_t          r_state;
    logic [SIZE-1:0] r_lfsr;
    logic [SIZE-1:0] r_cnt;
    logic [SIZE-1:0] r_poly;
    logic            r_ready;
    logic            r_found;
    logic            r_failure;

    logic [SIZE-1:0] w_nxt;
    logic [SIZE-1:0] w_cnt_nxt;
    logic            w_back;
    logic            w_full;

    // next Galois state and step count; the period limit 2^SIZE-1 is the all-ones count
    always_comb begin
        w_nxt     = {r_lfsr[SIZE-2:0], 1'b0} ^ (r_lfsr[SIZE-1] ? r_poly : '0);
        w_cnt_nxt = r_cnt + SIZE'(1);
        w_back    = w_nxt == SIZE'(1);
        w_full    = &w_cnt_nxt;
    end

    // test sequencer: latch, validate constant term, step until the state returns to 1
    always_ff @(posedge clk) begin
        if (res) begin
            r_state   <= IDLE;
            r_ready   <= 1'b0;
            r_found   <= 1'b0;
            r_failure <= 1'b0;
            r_lfsr    <= SIZE'(1);
            r_cnt     <= '0;
            r_poly    <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.ena) begin
                    r_poly  <= bus.coeffs[SIZE-1:0];
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_ready <= 1'b1;
                    r_lfsr  <= SIZE'(1);
                    r_cnt   <= '0;
                    if (!r_poly[0]) begin
                        r_failure <= 1'b1;
                        r_state   <= DONE_FAIL;
                    end else begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_lfsr <= w_nxt;
                    r_cnt  <= w_cnt_nxt;
                    if (w_back || w_full) begin
                        r_found   <= w_back && w_full;
                        r_failure <= !(w_back && w_full);
                        r_state   <= (w_back && w_full) ? DONE_FOUND : DONE_FAIL;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign bus.ready   = r_ready;
    assign bus.found   = r_found;
    assign bus.failure = r_failure;
endmodule

// File: tb/tb_lfsr_period_tester.sv
// tb_lfsr_period_tester: randomized period checks of a SIZE=4 tester against a polynomial-order model
module tb_lfsr_period_tester;
    localparam int SIZE  = 4;
    localparam int BYTES = 1;

    logic clk = 1'b0;
    logic res = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;

    lfsr_period_tester_if #(.BYTES(BYTES)) bus ();

    lfsr_period_tester #(.SIZE(SIZE), .BYTES(BYTES)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // order of x modulo x^SIZE + poly over GF(2); returns cycles from E0 to the result
    function automatic int ref_latency(input logic [7:0] c, output bit is_found);
        int p;
        int v;
        p = (1 << SIZE) | (int'(c) & ((1 << SIZE) - 1));
        is_found = 1'b0;
        if ((p & 1) == 0) return 1;
        v = 1;
        for (int k = 1; k < (1 << SIZE); k++) begin
            v = v << 1;
            if ((v >> SIZE) & 1) v = v ^ p;
            if (v == 1) begin
                is_found = (k == (1 << SIZE) - 1);
                return 1 + k;
            end
        end
        return 1 << SIZE;
    endfunction

    function automatic logic [2:0] outs();
        return {bus.ready, bus.found, bus.failure};
    endfunction

    // called #1 after edge E0; follows every cycle until well past the result
    task automatic watch(input logic [7:0] c, input bit drop, input string name);
        bit f;
        int lat;
        logic [2:0] exp;
        lat = ref_latency(c, f);
        for (int t = 0; t <= lat + 20; t++) begin
            exp = {t >= 1, f && t >= lat, !f && t >= lat};
            check($sformatf("%s c=%0h t=%0d", name, c, t), 32'(outs()), 32'(exp));
            if (drop && t == 3) begin
                bus.ena    = 1'b0;
                bus.coeffs = 8'($urandom);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        res     = 1'b1;
        bus.ena = 1'b0;
        @(posedge clk);
        #1;
        check("reset", 32'(outs()), 32'h0);
        @(negedge clk);
        res = 1'b0;
    endtask

    task automatic start(input logic [7:0] c, input bit drop, input string name);
        do_reset();
        bus.ena    = 1'b1;
        bus.coeffs = c;
        @(posedge clk);
        #1;
        watch(c, drop, name);
        bus.ena = 1'b0;
    endtask

    initial begin
        bus.ena    = 1'b0;
        bus.coeffs = '0;
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        check("idle", 32'(outs()), 32'h0);

        start(8'h03, 1'b0, "prim");
        start(8'h0F, 1'b0, "per5");
        start(8'h02, 1'b0, "noconst");
        start(8'hF3, 1'b0, "upperbits");
        start(8'h03, 1'b1, "enadrop");
        do_reset();

        // abort mid-run with ena held high: restart from the first IDLE edge after reset
        @(negedge clk);
        bus.ena    = 1'b1;
        bus.coeffs = 8'h03;
        @(posedge clk);
        repeat (7) @(negedge clk);
        res = 1'b1;
        @(posedge clk);
        #1;
        check("midreset", 32'(outs()), 32'h0);
        @(negedge clk);
        res = 1'b0;
        @(posedge clk);
        #1;
        watch(8'h03, 1'b0, "restart");
        bus.ena = 1'b0;

        // reset and ena together: reset wins, nothing starts
        @(negedge clk);
        res     = 1'b1;
        bus.ena = 1'b1;
        @(posedge clk);
        #1;
        check("res_ena", 32'(outs()), 32'h0);
        @(negedge clk);
        bus.ena = 1'b0;
        @(posedge clk);
        #1;
        check("res_ena_hold", 32'(outs()), 32'h0);
        res = 1'b0;

        for (int i = 0; i < 12; i++) start(8'($urandom), 1'($urandom), "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
